r5p_bus_arb: RTL and testbench
==============================

R5P_BUS_ARB -- requirements
Module: r5p_bus_arb

Interface
REQ-001 Parameter AW, default 17, address width of all ports.
REQ-002 Parameter DW, default 32, data width of all ports.
REQ-003 Parameter SW, default DW/8, byte-select width.
REQ-004 Parameter BN, default 2, number of initiator ports (2..8).
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 s_req  input  [BN]  per-initiator transfer request.
REQ-008 s_wen  input  [BN]  per-initiator write enable (1 write, 0 read).
REQ-009 s_adr  input  [BN][AW]  per-initiator address.
REQ-010 s_sel  input  [BN][SW]  per-initiator byte select.
REQ-011 s_wdt  input  [BN][DW]  per-initiator write data.
REQ-012 s_rdt  output  [BN][DW]  per-initiator read data.
REQ-013 s_ack  output  [BN]  per-initiator acknowledge.
REQ-014 m_req, m_wen, m_adr[AW], m_sel[SW], m_wdt[DW]  output  responder request fields.
REQ-015 m_rdt  input  [DW]  responder read data; m_ack  input  1  responder acknowledge.

Function
REQ-016 Transfer on any port completes in the cycle where req and ack are both high; read data valid on rdt in the cycle after that transfer.
REQ-017 State: ptr (round-robin priority index, 0..BN-1), lck (1 bit), idx (locked index, 0..BN-1).
REQ-018 Unlocked (lck=0): grant = first i with s_req[i]=1, searching ptr, ptr+1, ... modulo BN; no grant if s_req all zero.
REQ-019 Locked (lck=1): grant = idx regardless of other requests.
REQ-020 m_req = 1 only when a grant exists; m_wen/m_adr/m_sel/m_wdt combinationally equal the granted port fields, all zero when no grant.
REQ-021 s_ack[i] = m_ack & grant valid & grant==i; all other s_ack bits 0 (same cycle, combinational).
REQ-022 s_rdt[i] = m_rdt for every i (broadcast); each initiator samples only after its own read transfer.
REQ-023 Grant with m_ack=1: transfer completes; next ptr = (grant+1) mod BN, next lck = 0.
REQ-024 Grant with m_ack=0, unlocked: next lck = 1, next idx = grant; ptr unchanged.
REQ-025 Locked, s_req[idx]=0 (protocol violation, request withdrawn): next lck = 0, no transfer, ptr unchanged.
REQ-026 Back-to-back: a new grant is issued in the cycle immediately after a completed transfer; zero idle cycles.
REQ-027 Single active requester is granted every cycle regardless of ptr.
REQ-028 ptr wraps from BN-1 to 0.
REQ-029 No combinational path from m_ack to m_req or any m_* request field.

Reset
REQ-030 While rst=1: ptr=0, lck=0, idx=0; outputs then follow REQ-020..022 (all s_req=0 gives m_req=0, s_ack=0).
REQ-031 rst asserted mid-transfer (locked) drops the lock immediately; after release arbitration restarts from port 0.

Verification
REQ-032 BN=2, s_req=2'b11 continuously, m_ack=1 every cycle -> grants alternate 0,1,0,1; s_ack=2'b01,2'b10,...
REQ-033 s_req[1]=1 only, s_adr[1]=0x1_0008, s_wen[1]=1, s_wdt[1]=0x1, m_ack=1 -> m_adr=0x1_0008, m_wdt=0x1, s_ack=2'b10 same cycle.
REQ-034 Port 0 granted, m_ack=0 for 3 cycles while s_req[1] rises -> m_adr stays at port 0 value; 4th cycle m_ack=1 gives s_ack=2'b01; next cycle port 1 granted.
REQ-035 Read from port 1, m_ack=1 at cycle N, m_rdt=0xDEAD_BEEF at N+1 -> s_rdt[1]=0xDEAD_BEEF at N+1.
REQ-036 Locked on port 0, rst pulsed -> m_req=0 during reset; with s_req=2'b11 after release, port 0 granted first.
REQ-037 Locked on port 1, s_req[1] withdrawn, s_req[0]=1 -> next cycle port 0 granted, ptr unchanged.

Source files
------------

// File: rtl/r5p_bus_arb_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// r5p_bus_arb_if : initiator-side and responder-side bundle for r5p_bus_arb
// Revision 1.0
// ---------------------------------------------------------------------------
interface r5p_bus_arb_if #(
  parameter int AW = 17,
  parameter int DW = 32,
  parameter int SW = DW/8,
  parameter int BN = 2
) ();
  logic [BN-1:0]         s_req;
  logic [BN-1:0]         s_wen;
  logic [BN-1:0][AW-1:0] s_adr;
  logic [BN-1:0][SW-1:0] s_sel;
  logic [BN-1:0][DW-1:0] s_wdt;
  logic [BN-1:0][DW-1:0] s_rdt;
  logic [BN-1:0]         s_ack;

  logic                  m_req;
  logic                  m_wen;
  logic [AW-1:0]         m_adr;
  logic [SW-1:0]         m_sel;
  logic [DW-1:0]         m_wdt;
  logic [DW-1:0]         m_rdt;
  logic                  m_ack;

  // Arbiter view: initiator requests and responder replies come in.
  modport slave (
    input  s_req, s_wen, s_adr, s_sel, s_wdt, m_rdt, m_ack,
    output s_rdt, s_ack, m_req, m_wen, m_adr, m_sel, m_wdt
  );

  // Environment view: the initiators plus the responder.
  modport master (
    output s_req, s_wen, s_adr, s_sel, s_wdt, m_rdt, m_ack,
    input  s_rdt, s_ack, m_req, m_wen, m_adr, m_sel, m_wdt
  );
endinterface
`default_nettype wire

// File: rtl/r5p_bus_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// r5p_bus_arb : round-robin N:1 bus arbiter with grant lock until acknowledge
// Revision 1.0
// ---------------------------------------------------------------------------
module r5p_bus_arb #(
  parameter int AW = 17,
  parameter int DW = 32,
  parameter int SW = DW/8,
  parameter int BN = 2
) (
  input  logic             clk,
  input  logic             rst,
  r5p_bus_arb_if.slave     bus
);

  localparam int PW = (BN > 1) ? $clog2(BN) : 1;

  typedef enum logic {
    ST_OPEN = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [PW-1:0] idx, idx_nxt;
  logic          gnt_vld;
  logic [PW-1:0] gnt;
  logic [PW-1:0] cand;
  int            pos;

  // Scan from the lowest priority upward so the highest-priority hit wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    cand    = '0;
    pos     = 0;
    if (state == ST_LOCK) begin
      gnt_vld = bus.s_req[idx];
      gnt     = idx;
    end else begin
      for (int k = BN-1; k >= 0; k--) begin
        pos = int'(ptr) + k;
        if (pos >= BN) pos = pos - BN;
        cand = PW'(pos);
        if (bus.s_req[cand]) begin
          gnt_vld = 1'b1;
          gnt     = cand;
        end
      end
    end
  end

  assign bus.m_req = gnt_vld;
  assign bus.m_wen = gnt_vld & bus.s_wen[gnt];
  assign bus.m_adr = gnt_vld ? bus.s_adr[gnt] : '0;
  assign bus.m_sel = gnt_vld ? bus.s_sel[gnt] : '0;
  assign bus.m_wdt = gnt_vld ? bus.s_wdt[gnt] : '0;

  always_comb begin
    bus.s_ack = '0;
    bus.s_rdt = '0;
    for (int i = 0; i < BN; i++) begin
      bus.s_ack[i] = bus.m_ack & gnt_vld & (gnt == PW'(i));
      bus.s_rdt[i] = bus.m_rdt;
    end
  end

  // A stalled grant is held; a withdrawn locked request releases the lock.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx;
    if (gnt_vld && bus.m_ack) begin
      state_nxt = ST_OPEN;
      ptr_nxt   = (gnt == PW'(BN-1)) ? '0 : gnt + 1'b1;
    end else if (gnt_vld) begin
      state_nxt = ST_LOCK;
      idx_nxt   = gnt;
    end else begin
      state_nxt = ST_OPEN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_OPEN;
      ptr   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      idx   <= idx_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_r5p_bus_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_r5p_bus_arb : vector table, directed corner cases and random model check
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_r5p_bus_arb;

  localparam int AW = 17;
  localparam int DW = 32;
  localparam int SW = DW/8;
  localparam int BN = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  r5p_bus_arb_if #(.AW(AW), .DW(DW), .SW(SW), .BN(BN)) bus ();

  r5p_bus_arb #(.AW(AW), .DW(DW), .SW(SW), .BN(BN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arbiter state: rotating priority start, lock flag and owner.
  int mdl_ptr;
  int mdl_lck;
  int mdl_idx;

  typedef struct {
    logic [BN-1:0] req;
    logic          ack;
    int            gnt;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int model_grant(input logic [BN-1:0] req);
    if (mdl_lck != 0) return req[mdl_idx] ? mdl_idx : -1;
    for (int k = 0; k < BN; k++) begin
      if (req[(mdl_ptr + k) % BN]) return (mdl_ptr + k) % BN;
    end
    return -1;
  endfunction

  task automatic model_update(input int g, input logic ack);
    if (g >= 0 && ack) begin
      mdl_ptr = (g + 1) % BN;
      mdl_lck = 0;
    end else if (g >= 0) begin
      mdl_lck = 1;
      mdl_idx = g;
    end else begin
      mdl_lck = 0;
    end
  endtask

  task automatic model_reset();
    mdl_ptr = 0;
    mdl_lck = 0;
    mdl_idx = 0;
  endtask

  task automatic check_outputs(input string tag, input int g);
    logic [BN-1:0] exp_ack;
    exp_ack = '0;
    if (g >= 0 && bus.m_ack) exp_ack[g] = 1'b1;
    chk({tag, " m_req"}, 64'(bus.m_req), 64'(g >= 0));
    chk({tag, " s_ack"}, 64'(bus.s_ack), 64'(exp_ack));
    chk({tag, " m_adr"}, 64'(bus.m_adr), (g >= 0) ? 64'(bus.s_adr[g]) : 64'd0);
    chk({tag, " m_wen"}, 64'(bus.m_wen), (g >= 0) ? 64'(bus.s_wen[g]) : 64'd0);
    chk({tag, " m_sel"}, 64'(bus.m_sel), (g >= 0) ? 64'(bus.s_sel[g]) : 64'd0);
    chk({tag, " m_wdt"}, 64'(bus.m_wdt), (g >= 0) ? 64'(bus.s_wdt[g]) : 64'd0);
    for (int i = 0; i < BN; i++)
      chk($sformatf("%s s_rdt%0d", tag, i), 64'(bus.s_rdt[i]), 64'(bus.m_rdt));
  endtask

  // Inputs are driven just after a rising edge; outputs compared at the falling edge.
  task automatic step(input string tag, input int g);
    @(negedge clk);
    check_outputs(tag, g);
    model_update(g, bus.m_ack);
    @(posedge clk);
    #1;
  endtask

  task automatic set_fixed_fields();
    bus.s_adr[0] = 17'h0_0100; bus.s_wen[0] = 1'b0; bus.s_sel[0] = 4'h3; bus.s_wdt[0] = 32'hAAAA_5555;
    bus.s_adr[1] = 17'h1_0008; bus.s_wen[1] = 1'b1; bus.s_sel[1] = 4'hF; bus.s_wdt[1] = 32'h0000_0001;
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    bus.s_req = '0;
    bus.m_ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    rst       = 1'b1;
    bus.s_req = '0;
    bus.m_ack = 1'b1;
    bus.m_rdt = 32'h1234_5678;
    set_fixed_fields();

    // Reset state: no request means no grant even with a stray acknowledge.
    @(negedge clk);
    chk("reset m_req", 64'(bus.m_req), 64'd0);
    chk("reset s_ack", 64'(bus.s_ack), 64'd0);
    chk("reset m_adr", 64'(bus.m_adr), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Hand-derived cycle sequence from reset (ptr=0, unlocked).
    tbl[0]  = '{req: 2'b00, ack: 1'b0, gnt: -1};
    tbl[1]  = '{req: 2'b11, ack: 1'b1, gnt:  0};
    tbl[2]  = '{req: 2'b11, ack: 1'b1, gnt:  1};
    tbl[3]  = '{req: 2'b11, ack: 1'b1, gnt:  0};
    tbl[4]  = '{req: 2'b10, ack: 1'b1, gnt:  1};
    tbl[5]  = '{req: 2'b10, ack: 1'b1, gnt:  1};
    tbl[6]  = '{req: 2'b01, ack: 1'b0, gnt:  0};
    tbl[7]  = '{req: 2'b11, ack: 1'b0, gnt:  0};
    tbl[8]  = '{req: 2'b11, ack: 1'b0, gnt:  0};
    tbl[9]  = '{req: 2'b11, ack: 1'b1, gnt:  0};
    tbl[10] = '{req: 2'b11, ack: 1'b0, gnt:  1};
    tbl[11] = '{req: 2'b01, ack: 1'b0, gnt: -1};
    tbl[12] = '{req: 2'b01, ack: 1'b1, gnt:  0};
    tbl[13] = '{req: 2'b01, ack: 1'b0, gnt:  0};
    tbl[14] = '{req: 2'b10, ack: 1'b0, gnt: -1};
    tbl[15] = '{req: 2'b11, ack: 1'b1, gnt:  1};
    tbl[16] = '{req: 2'b00, ack: 1'b1, gnt: -1};
    for (int i = 0; i < 17; i++) begin
      bus.s_req = tbl[i].req;
      bus.m_ack = tbl[i].ack;
      step($sformatf("vec%0d", i), tbl[i].gnt);
    end

    // Read on port 1: data returned in the cycle after the acknowledge.
    bus.s_wen[1] = 1'b0;
    bus.s_req    = 2'b10;
    bus.m_ack    = 1'b1;
    step("rd_xfer", model_grant(bus.s_req));
    bus.s_req = 2'b00;
    bus.m_ack = 1'b0;
    bus.m_rdt = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rd_data s_rdt1", 64'(bus.s_rdt[1]), 64'h0000_0000_DEAD_BEEF);
    @(posedge clk);
    #1;
    set_fixed_fields();

    // Lock on port 1 (ptr=1), then assert reset mid-cycle.
    sync_reset();
    bus.s_req = 2'b11;
    bus.m_ack = 1'b1;
    step("pre_rst0", 0);
    bus.m_ack = 1'b0;
    step("pre_rst1", 1);
    rst       = 1'b1;
    bus.s_req = 2'b01;
    #2;
    chk("rst_async m_req", 64'(bus.m_req), 64'd1);
    chk("rst_async m_adr", 64'(bus.m_adr), 64'h0_0100);
    bus.s_req = 2'b00;
    #1;
    chk("rst_idle m_req", 64'(bus.m_req), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    bus.s_req = 2'b11;
    bus.m_ack = 1'b1;
    step("post_rst", 0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      bus.s_req = BN'($urandom_range(0, (1 << BN) - 1));
      for (int i = 0; i < BN; i++) begin
        bus.s_adr[i] = AW'($urandom);
        bus.s_wen[i] = 1'($urandom);
        bus.s_sel[i] = SW'($urandom);
        bus.s_wdt[i] = DW'($urandom);
      end
      bus.m_ack = ($urandom_range(0, 2) != 0);
      bus.m_rdt = DW'($urandom);
      step($sformatf("rand%0d", n), model_grant(bus.s_req));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
